// File: rtl/wave_capture.sv
// Triggered waveform capture into a double-buffered 512-entry RAM.
// Captures 256 samples after a negative-to-non-negative crossing, then waits for display blanking to swap halves.
module wave_capture #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SAMPLE_W-1:0] r_prev_sample;
  logic                r_idle_d;
  logic [7:0]          r_count;
  logic                r_read_index;
  logic                r_write_enable;
  logic [8:0]          r_write_address;
  logic [7:0]          r_write_sample;

  logic                w_trigger;
  logic                w_idle_rise;
  logic [7:0]          w_sample_byte;
  logic [7:0]          w_count_nxt;
  logic                w_read_index_nxt;
  logic                w_we_nxt;
  logic [8:0]          w_waddr_nxt;
  logic [7:0]          w_wsample_nxt;
  logic                w_unused_prev_lsbs;

  // Only the sign of the previous sample matters for the trigger.
  assign w_unused_prev_lsbs = ^r_prev_sample[SAMPLE_W-2:0];

  assign w_trigger     = new_sample_ready & r_prev_sample[SAMPLE_W-1] & ~new_sample_in[SAMPLE_W-1];
  assign w_idle_rise   = wave_display_idle & ~r_idle_d;
  assign w_sample_byte = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_ARMED;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ARMED: begin
        if (w_trigger) w_state_nxt = ST_ACTIVE;
        else           w_state_nxt = ST_ARMED;
      end
      ST_ACTIVE: begin
        if (new_sample_ready && (r_count == 8'hFF)) w_state_nxt = ST_WAIT;
        else                                        w_state_nxt = ST_ACTIVE;
      end
      ST_WAIT: begin
        if (w_idle_rise) w_state_nxt = ST_ARMED;
        else             w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_ARMED;
    endcase
  end

  // Next values for the registered RAM-side outputs, counter and buffer select.
  always_comb begin
    w_count_nxt      = r_count;
    w_read_index_nxt = r_read_index;
    w_we_nxt         = 1'b0;
    w_waddr_nxt      = r_write_address;
    w_wsample_nxt    = r_write_sample;
    case (r_state)
      ST_ARMED: begin
        if (w_trigger) w_count_nxt = 8'd0;
        else           w_count_nxt = r_count;
      end
      ST_ACTIVE: begin
        if (new_sample_ready) begin
          w_we_nxt      = 1'b1;
          w_waddr_nxt   = {~r_read_index, r_count};
          w_wsample_nxt = w_sample_byte;
          w_count_nxt   = r_count + 8'd1;
        end else begin
          w_we_nxt      = 1'b0;
        end
      end
      ST_WAIT: begin
        if (w_idle_rise) w_read_index_nxt = ~r_read_index;
        else             w_read_index_nxt = r_read_index;
      end
      default: begin
        w_count_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_sample   <= '0;
      r_idle_d        <= 1'b0;
      r_count         <= 8'd0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= 9'd0;
      r_write_sample  <= 8'd0;
    end else begin
      if (new_sample_ready) r_prev_sample <= new_sample_in;
      r_idle_d        <= wave_display_idle;
      r_count         <= w_count_nxt;
      r_read_index    <= w_read_index_nxt;
      r_write_enable  <= w_we_nxt;
      r_write_address <= w_waddr_nxt;
      r_write_sample  <= w_wsample_nxt;
    end
  end

  assign write_address = r_write_address;
  assign write_enable  = r_write_enable;
  assign write_sample  = r_write_sample;
  assign read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Randomised and directed bench for wave_capture with a behavioural model and a write scoreboard.
module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture #(.SAMPLE_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;

  // Reference model: capture progress expressed as "triggered" plus samples written so far.
  bit m_triggered;
  int m_written;
  int m_prev;
  bit m_idle_prev;
  bit m_ri;
  int q_addr[$];
  int q_samp[$];

  task automatic check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_triggered = 1'b0;
    m_written   = 0;
    m_prev      = 0;
    m_idle_prev = 1'b0;
    m_ri        = 1'b0;
    q_addr.delete();
    q_samp.delete();
  endtask

  // Drive one cycle of inputs, predict its effect, and advance past the rising edge.
  task automatic step(input bit nsr, input int s, input bit idle);
    bit ri_next;
    bit rise;
    new_sample_ready  = nsr;
    new_sample_in     = s[15:0];
    wave_display_idle = idle;
    ri_next = m_ri;
    rise    = idle && !m_idle_prev;
    if (!m_triggered) begin
      if (nsr && (m_prev < 0) && (s >= 0)) begin
        m_triggered = 1'b1;
        m_written   = 0;
      end
    end else if (m_written < 256) begin
      if (nsr) begin
        q_addr.push_back((m_ri ? 0 : 256) + m_written);
        q_samp.push_back((s + 32768) / 256);
        m_written++;
      end
    end else begin
      if (rise) begin
        ri_next     = !m_ri;
        m_triggered = 1'b0;
        m_written   = 0;
      end
    end
    if (nsr) m_prev = s;
    m_idle_prev = idle;
    @(posedge clk);
    m_ri = ri_next;
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic apply_reset();
    #1;
    reset = 1'b0;
    #1;
    check_eq("async_reset_we",    int'(write_enable),  0);
    check_eq("async_reset_addr",  int'(write_address), 0);
    check_eq("async_reset_samp",  int'(write_sample),  0);
    check_eq("async_reset_rdidx", int'(read_index),    0);
    model_reset();
    new_sample_ready  = 1'b0;
    wave_display_idle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: compares every presented write against the scoreboard and tracks read_index.
  int mon_addr;
  int mon_samp;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      n_checks++;
      if (read_index !== m_ri) begin
        n_errors++;
        $display("FAIL read_index: got %b, expected %b", read_index, m_ri);
      end
      n_checks++;
      if (write_enable === 1'b1) begin
        n_writes++;
        if (q_addr.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_write: addr 0x%0h sample 0x%0h, expected no write", write_address, write_sample);
        end else begin
          mon_addr = q_addr.pop_front();
          mon_samp = q_samp.pop_front();
          if ((int'(write_address) != mon_addr) || (int'(write_sample) != mon_samp)) begin
            n_errors++;
            $display("FAIL write_data: got addr 0x%0h sample 0x%0h, expected addr 0x%0h sample 0x%0h",
                     write_address, write_sample, mon_addr, mon_samp);
          end
        end
      end else if (write_enable !== 1'b0) begin
        n_errors++;
        $display("FAIL write_enable_x: got %b, expected 0 or 1", write_enable);
      end
    end
  end

  int w0;
  int s;
  bit idle_r;

  initial begin
    reset             = 1'b0;
    new_sample_ready  = 1'b0;
    new_sample_in     = 16'd0;
    wave_display_idle = 1'b0;
    model_reset();
    #2;
    check_eq("reset_we",    int'(write_enable),  0);
    check_eq("reset_addr",  int'(write_address), 0);
    check_eq("reset_samp",  int'(write_sample),  0);
    check_eq("reset_rdidx", int'(read_index),    0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // First trigger and the 0x1234 write
    w0 = n_writes;
    step(1'b1, -5, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 3, 1'b0);
    idle_steps(2);
    check_eq("no_write_before_trigger", n_writes - w0, 0);
    step(1'b1, 'h1234, 1'b0);
    idle_steps(2);
    check_eq("first_write_count", n_writes - w0, 1);

    // Rest of the capture: ramp with extreme values, then the 257th strobe
    for (int i = 1; i < 256; i++) begin
      if (i == 10)      s = -32768;
      else if (i == 11) s = 32767;
      else if (i == 12) s = 0;
      else              s = i * 128 - 16000;
      step(1'b1, s, 1'b0);
      if (i % 3 == 0) step(1'b0, 0, 1'b0);
    end
    idle_steps(2);
    check_eq("full_capture_count", n_writes - w0, 256);
    step(1'b1, 100, 1'b0);
    idle_steps(2);
    check_eq("no_write_in_wait", n_writes - w0, 256);

    // Idle held high for 10 cycles swaps exactly once
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1);
    check_eq("swap_once_rdidx", int'(read_index), 1);
    step(1'b0, 0, 1'b0);

    // Idle edge in ARMED and during ACTIVE is ignored; capture goes to the lower half
    w0 = n_writes;
    step(1'b1, -7, 1'b0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    step(1'b1, 5, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, (i * 97) % 20000 - 10000, (i % 40) inside {[20:25]});
    end
    idle_steps(2);
    check_eq("second_capture_count", n_writes - w0, 256);
    check_eq("rdidx_unchanged_active", int'(read_index), 1);

    // Swap coinciding with a strobe: no trigger evaluated, prev_sample still updated
    step(1'b1, -9, 1'b0);
    step(1'b1, 6, 1'b1);
    w0 = n_writes;
    step(1'b1, 7, 1'b0);
    idle_steps(2);
    check_eq("no_trigger_on_swap_cycle", n_writes - w0, 0);
    check_eq("rdidx_after_second_swap", int'(read_index), 0);

    // Reset in the middle of a capture
    step(1'b1, -1, 1'b0);
    step(1'b1, 2, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, i * 50, 1'b0);
    apply_reset();
    w0 = n_writes;
    step(1'b1, 5, 1'b0);
    step(1'b1, 9, 1'b0);
    step(1'b1, -1, 1'b0);
    idle_steps(2);
    check_eq("no_write_after_reset", n_writes - w0, 0);
    step(1'b1, 1, 1'b0);
    step(1'b1, 300, 1'b0);
    idle_steps(2);
    check_eq("write_after_fresh_trigger", n_writes - w0, 1);

    // Randomised traffic
    idle_r = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 29) == 0) idle_r = ~idle_r;
      s = int'($urandom_range(0, 65535)) - 32768;
      step($urandom_range(0, 2) != 0, s, idle_r);
      if (i == 3000) apply_reset();
    end
    idle_steps(3);
    check_eq("scoreboard_drained", q_addr.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 16, giving the width of the signed input sample; only values ≥ 8 are legal.
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-004 new_sample_ready  input  1  single-cycle strobe; each high cycle SHALL count as one new sample.
REQ-005 new_sample_in  input  SAMPLE_W  two's-complement audio sample, valid when new_sample_ready is high.
REQ-006 wave_display_idle  input  1  high during display vertical blanking; safe-to-swap indication from the display side.
REQ-007 write_address  output  9  RAM write address {~read_index, count[7:0]}.
REQ-008 write_enable  output  1  one-cycle RAM write strobe.
REQ-009 write_sample  output  8  unsigned (offset-binary) sample to store.
REQ-010 read_index  output  1  buffer half the display reads; capture always writes the other half.

Function
REQ-011 The block SHALL implement three states: ARMED (waiting for trigger), ACTIVE (writing 256 samples), WAIT (buffer full, awaiting swap).
REQ-012 prev_sample register SHALL load new_sample_in on every new_sample_ready, in every state.
REQ-013 Trigger SHALL be: new_sample_ready high, prev_sample MSB = 1 (negative), new_sample_in MSB = 0 (zero or positive).
REQ-014 ARMED: on trigger, go to ACTIVE with count = 0; the trigger sample itself SHALL NOT be written.
REQ-015 ACTIVE: each new_sample_ready SHALL produce, on the next cycle, write_enable = 1 for exactly one cycle with write_address = {~read_index, count} and write_sample = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]}.
REQ-016 ACTIVE: count SHALL increment by 1 per written sample; after the write at count = 255, state SHALL become WAIT and count SHALL wrap to 0.
REQ-017 WAIT: new_sample_ready SHALL cause no write and no trigger evaluation.
REQ-018 A wave_display_idle rising edge (registered previous value 0, current 1) SHALL be detected in all states, but SHALL act only in WAIT.
REQ-019 WAIT: on the detected rising edge, read_index SHALL toggle and state SHALL become ARMED, both in the same clock edge.
REQ-020 wave_display_idle held high across the transition SHALL NOT cause a second toggle; a new rising edge SHALL be required.
REQ-021 An idle edge and new_sample_ready in the same cycle in WAIT: swap SHALL occur, prev_sample SHALL update, no trigger SHALL be evaluated that cycle.
REQ-022 An idle edge in ARMED or ACTIVE SHALL be ignored (no toggle, no state change).
REQ-023 write_enable SHALL be 0 in every cycle not specified by REQ-015.
REQ-024 All outputs SHALL be driven from registers; write_address SHALL use the read_index value current at the time of the write.

Reset
REQ-025 While reset is low: state = ARMED, count = 0, read_index = 0, prev_sample = 0, registered idle = 0, write_enable = 0, write_address = 0, write_sample = 0.
REQ-026 Reset asserted mid-ACTIVE or mid-WAIT SHALL abandon the capture with no further writes; after release, a fresh trigger SHALL be required.
REQ-027 The first sample after reset SHALL NOT trigger, because prev_sample is 0 (non-negative).

Verification
REQ-028 Reset, then samples -5, +3 (strobes) -> no write for -5 or +3; state ACTIVE after +3; next sample 0x1234 -> write_enable pulse, write_address = 0x100, write_sample = 0x92.
REQ-029 After trigger, 256 strobes of ramp values -> exactly 256 writes, addresses 0x100..0x1FF in order, then state WAIT; a 257th strobe produces no write.
REQ-030 In WAIT, raise wave_display_idle and hold it for 10 cycles -> read_index goes 0→1 exactly once; the next capture writes addresses 0x000..0x0FF.
REQ-031 Idle rising edge during ARMED and during ACTIVE -> read_index unchanged, writes continue uninterrupted.
REQ-032 Reset low at count = 100 in ACTIVE -> outputs zero immediately (asynchronous); after release, samples -1, +1 are required before any write occurs.
REQ-033 Sample -32768 written in ACTIVE -> write_sample = 0x00; +32767 -> 0xFF; 0 -> 0x80.
